// File: rtl/univ_shift_reg_burst_if.sv
// univ_shift_reg_burst_if
// Bundles the operation controls and the register outputs of the universal
// shift register core. clk and rst_n are not part of the bundle.
//   ena        : clock enable
//   mode       : operation select (3 bits)
//   d          : parallel load data
//   s_in       : serial fill bit for logical shifts
//   shamt      : burst step count
//   start      : burst request
//   q          : register contents
//   s_out_msb  : q[WIDTH-1]
//   s_out_lsb  : q[0]
//   busy       : burst in progress
//   done       : one-cycle burst completion pulse
// master drives the controls and observes the outputs; slave is the core.
interface univ_shift_reg_burst_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
);
    logic             ena;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             s_in;
    logic [SHW-1:0]   shamt;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             s_out_msb;
    logic             s_out_lsb;
    logic             busy;
    logic             done;

    modport master (
        output ena, mode, d, s_in, shamt, start,
        input  q, s_out_msb, s_out_lsb, busy, done
    );

    modport slave (
        input  ena, mode, d, s_in, shamt, start,
        output q, s_out_msb, s_out_lsb, busy, done
    );
endinterface

// File: rtl/univ_shift_reg_burst.sv
// univ_shift_reg_burst
// Universal WIDTH-bit shift register (hold, shift left/right, load, rotate
// left/right, arithmetic shift right) with a burst engine: one accepted
// start performs shamt consecutive steps of the latched shift mode, with a
// busy flag while running and a one-cycle done pulse on completion.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous reset, ACTIVE-HIGH despite its name
//   bus    : univ_shift_reg_burst_if.slave (controls in, register state out)
module univ_shift_reg_burst #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    univ_shift_reg_burst_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_reg, q_nxt;
    logic [SHW-1:0]   cnt, cnt_nxt;
    logic [2:0]       lmode, lmode_nxt;
    logic             done_reg, done_nxt;

    // One step of the selected operation applied to the current contents.
    function automatic logic [WIDTH-1:0] step_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             fill
    );
        logic [WIDTH-1:0] res;
        case (op)
            3'b001:  res = {cur[WIDTH-2:0], fill};
            3'b010:  res = ld;
            3'b011:  res = {fill, cur[WIDTH-1:1]};
            3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b101:  res = {cur[0], cur[WIDTH-1:1]};
            3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default: res = cur;
        endcase
        return res;
    endfunction

    // Modes eligible for a burst; hold, load and reserved run as single ops.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b011) || (op == 3'b100) ||
               (op == 3'b101) || (op == 3'b110);
    endfunction

    always_comb begin
        state_nxt = state;
        q_nxt     = q_reg;
        cnt_nxt   = cnt;
        lmode_nxt = lmode;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && is_shift(bus.mode)) begin
                    // The accepting edge only latches the burst; q moves
                    // from the next enabled edge on.
                    if (bus.shamt != '0) begin
                        state_nxt = RUN;
                        cnt_nxt   = bus.shamt;
                        lmode_nxt = bus.mode;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end else begin
                    q_nxt = step_op(bus.mode, q_reg, bus.d, bus.s_in);
                end
            end
            RUN: begin
                // s_in is still live for logical shifts during a burst.
                q_nxt   = step_op(lmode, q_reg, bus.d, bus.s_in);
                cnt_nxt = cnt - 1'b1;
                if (cnt == SHW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            q_reg    <= '0;
            cnt      <= '0;
            lmode    <= 3'b000;
            done_reg <= 1'b0;
        end else if (bus.ena) begin
            state    <= state_nxt;
            q_reg    <= q_nxt;
            cnt      <= cnt_nxt;
            lmode    <= lmode_nxt;
            done_reg <= done_nxt;
        end
    end

    assign bus.q         = q_reg;
    assign bus.s_out_msb = q_reg[WIDTH-1];
    assign bus.s_out_lsb = q_reg[0];
    assign bus.busy      = (state == RUN);
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// tb_univ_shift_reg_burst
// Scoreboard bench for univ_shift_reg_burst (WIDTH=8). The driver applies
// inputs at the falling edge, advances an arithmetic reference model and
// queues the expected post-edge outputs; an independent monitor pops and
// compares after every rising edge. Directed scenarios are followed by a
// randomized phase.
module tb_univ_shift_reg_burst;
    localparam int W  = 8;
    localparam int SW = 4;

    logic clk;
    logic rst_n;

    univ_shift_reg_burst_if #(.WIDTH(W), .SHW(SW)) bus ();

    univ_shift_reg_burst #(.WIDTH(W), .SHW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q;
        bit busy;
        bit done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: remaining burst steps replaces any FSM notion.
    int m_q    = 0;
    int m_left = 0;
    int m_mode = 0;
    bit m_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    endtask

    // One operation expressed as plain integer arithmetic on an unsigned value.
    function automatic int ref_op(input int op, input int cur, input int din, input int fill);
        int top  = 1 << (W - 1);
        int full = 1 << W;
        case (op)
            1:       return (cur * 2 + fill) % full;
            2:       return din;
            3:       return cur / 2 + fill * top;
            4:       return (cur * 2) % full + cur / top;
            5:       return cur / 2 + (cur % 2) * top;
            6:       return cur / 2 + ((cur >= top) ? top : 0);
            default: return cur;
        endcase
    endfunction

    function automatic bit ref_shift(input int op);
        return (op == 1) || (op == 3) || (op == 4) || (op == 5) || (op == 6);
    endfunction

    // Advance the model with the inputs currently applied, queue the
    // expectation, then move through one full clock period.
    task automatic tick();
        exp_t e;
        if (rst_n) begin
            m_q = 0; m_left = 0; m_done = 1'b0; m_mode = 0;
        end else if (bus.ena) begin
            if (m_left == 0) begin
                if (bus.start && ref_shift(int'(bus.mode))) begin
                    if (bus.shamt != 0) begin
                        m_mode = int'(bus.mode);
                        m_left = int'(bus.shamt);
                        m_done = 1'b0;
                    end else begin
                        m_done = 1'b1;
                    end
                end else begin
                    m_q    = ref_op(int'(bus.mode), m_q, int'(bus.d), int'(bus.s_in));
                    m_done = 1'b0;
                end
            end else begin
                m_q    = ref_op(m_mode, m_q, int'(bus.d), int'(bus.s_in));
                m_left = m_left - 1;
                m_done = (m_left == 0);
            end
        end
        e.q    = m_q;
        e.busy = (m_left != 0);
        e.done = m_done;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every rising edge presents a new register state.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_q",    int'(bus.q),         e.q);
            check("sb_busy", int'(bus.busy),      int'(e.busy));
            check("sb_done", int'(bus.done),      int'(e.done));
            check("sb_msb",  int'(bus.s_out_msb), (e.q >> (W - 1)) & 1);
            check("sb_lsb",  int'(bus.s_out_lsb), e.q & 1);
        end
    end

    task automatic drive(input bit e, input int m, input int dv, input bit si, input int sh, input bit st);
        bus.ena   = e;
        bus.mode  = 3'(m);
        bus.d     = 8'(dv);
        bus.s_in  = si;
        bus.shamt = 4'(sh);
        bus.start = st;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b0;
        check("reset_q",    int'(bus.q),    0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);

        // Load 0xA5, rotate left by 3.
        drive(1, 2, 'hA5, 0, 0, 0); tick();
        drive(1, 4, 0, 0, 3, 1);    tick();
        check("rotl_busy_start", int'(bus.busy), 1);
        check("rotl_q_start",    int'(bus.q),    'hA5);
        drive(1, 0, 0, 0, 0, 0);
        tick(); check("rotl_step1", int'(bus.q), 'h4B);
        tick(); check("rotl_step2", int'(bus.q), 'h96);
        tick(); check("rotl_final", int'(bus.q), 'h2D);
        check("rotl_done", int'(bus.done), 1);
        check("rotl_busy_end", int'(bus.busy), 0);
        tick(); check("rotl_done_clear", int'(bus.done), 0);

        // Load 0x90, arithmetic shift right by 2.
        drive(1, 2, 'h90, 0, 0, 0); tick();
        drive(1, 6, 0, 0, 2, 1);    tick();
        drive(1, 0, 0, 0, 0, 0);
        tick(); check("asr_step1", int'(bus.q), 'hC8);
        tick(); check("asr_final", int'(bus.q), 'hE4);
        check("asr_done", int'(bus.done), 1);
        tick(); check("asr_busy_after", int'(bus.busy), 0);

        // Load 0x81, shift left by 4 with s_in=1; mode/d/start churn ignored.
        drive(1, 2, 'h81, 1, 0, 0); tick();
        drive(1, 1, 0, 1, 4, 1);    tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 2, int'($urandom_range(0, 255)), 1, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            tick();
        end
        check("shl_final", int'(bus.q), 'h1F);
        check("shl_done",  int'(bus.done), 1);
        drive(1, 0, 0, 0, 0, 0); tick();

        // Rotate right by 8, reset after 3 steps.
        drive(1, 2, 'h3C, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 8, 1);    tick();
        drive(1, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        check("rotr_step3", int'(bus.q), 'h87);
        rst_n = 1'b1; tick(); rst_n = 1'b0;
        check("abort_q",    int'(bus.q),    0);
        check("abort_busy", int'(bus.busy), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", int'(bus.done), 0);
        end

        // Clock enable low mid-burst.
        drive(1, 2, 'h01, 0, 0, 0); tick();
        drive(1, 4, 0, 0, 2, 1);    tick();
        drive(1, 0, 0, 0, 0, 0);    tick();
        check("ena_step1", int'(bus.q), 'h02);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        check("ena_frozen_q",    int'(bus.q),    'h02);
        check("ena_frozen_busy", int'(bus.busy), 1);
        drive(1, 0, 0, 0, 0, 0); tick();
        check("ena_resume_q",    int'(bus.q),    'h04);
        check("ena_resume_done", int'(bus.done), 1);

        // shamt=0 burst request, then free-running shift-left fill.
        drive(1, 1, 0, 1, 0, 1); tick();
        check("zero_done", int'(bus.done), 1);
        check("zero_q",    int'(bus.q),    'h04);
        drive(1, 2, 0, 0, 0, 0); tick();
        check("zero_done_clear", int'(bus.done), 0);
        drive(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) tick();
        check("fill_ff", int'(bus.q), 'hFF);

        // Randomized phase.
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), $urandom_range(0, 9) < 4);
            tick();
        end
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        tick();

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
